// File: rtl/regfile_search_ctrl.sv
// Linear-search sequencer over a register-file address window.
// Scans one register per cycle for a key and writes the hit index or a miss code to a destination register.
module regfile_search_ctrl #(
  parameter int                 ADDR_W    = 5,
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  MISS_CODE = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] key,
  input  logic [ADDR_W-1:0] lo_addr,
  input  logic [ADDR_W-1:0] hi_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] found_idx,
  output logic [ADDR_W-1:0] rf_rs_addr,
  input  logic [DATA_W-1:0] rf_rs_data,
  output logic              rf_regwrite,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [DATA_W-1:0] rf_write_data
);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] key_q;
  logic [ADDR_W-1:0] hi_q;
  logic [ADDR_W-1:0] dst_q;
  logic              empty_q;
  logic              hit;
  logic              at_end;

  // rf_rs_addr doubles as the scan pointer, so it is zero outside SCAN by construction
  always_comb begin
    hit    = (rf_rs_data == key_q);
    at_end = (rf_rs_addr == hi_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      key_q         <= '0;
      hi_q          <= '0;
      dst_q         <= '0;
      empty_q       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      found_idx     <= '0;
      rf_rs_addr    <= '0;
      rf_regwrite   <= 1'b0;
      rf_rd_addr    <= '0;
      rf_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            key_q      <= key;
            hi_q       <= hi_addr;
            dst_q      <= dst_addr;
            empty_q    <= (lo_addr > hi_addr);
            rf_rs_addr <= lo_addr;
            found      <= 1'b0;
            found_idx  <= '0;
            busy       <= 1'b1;
            state      <= SCAN;
          end
        end

        SCAN: begin
          if (abort) begin
            rf_rs_addr <= '0;
            done       <= 1'b1;
            state      <= DONE;
          end else if (empty_q || hit || at_end) begin
            // An empty window is a miss even if the data at lo happens to match
            rf_rs_addr  <= '0;
            rf_regwrite <= 1'b1;
            rf_rd_addr  <= dst_q;
            state       <= WRITE;
            if (!empty_q && hit) begin
              found         <= 1'b1;
              found_idx     <= rf_rs_addr;
              rf_write_data <= DATA_W'(rf_rs_addr);
            end else begin
              rf_write_data <= MISS_CODE;
            end
          end else begin
            rf_rs_addr <= rf_rs_addr + ADDR_W'(1);
          end
        end

        WRITE: begin
          rf_regwrite   <= 1'b0;
          rf_rd_addr    <= '0;
          rf_write_data <= '0;
          done          <= 1'b1;
          state         <= DONE;
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
